// File: rtl/fb_writer_if.sv
// Pixel-stream and Wishbone-master signal bundle for fb_writer.
// slave is the writer's own view; master is the pixel-source/SDRAM-side view.
interface fb_writer_if;
    logic [15:0] pix_data;
    logic        pix_sof;
    logic        pix_valid;
    logic        pix_ready;
    logic [31:0] wb_adr;
    logic [15:0] wb_dat_ms;
    logic [1:0]  wb_sel;
    logic        wb_we;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_ack;

    modport slave (
        input  pix_data, pix_sof, pix_valid, wb_ack,
        output pix_ready, wb_adr, wb_dat_ms, wb_sel, wb_we, wb_cti, wb_bte, wb_cyc, wb_stb
    );

    modport master (
        output pix_data, pix_sof, pix_valid, wb_ack,
        input  pix_ready, wb_adr, wb_dat_ms, wb_sel, wb_we, wb_cti, wb_bte, wb_cyc, wb_stb
    );
endinterface

// File: rtl/fb_writer.sv
// Framebuffer write side: RGB565 stream -> small FIFO -> one Wishbone classic write per pixel
// at BASE_ADR + 2*(HDISP*y + x).
module fb_writer #(
    parameter int unsigned HDISP      = 640,
    parameter int unsigned VDISP      = 480,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADR   = 32'h0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    fb_writer_if.slave io_bus,
    output logic       o_frame_done,
    output logic       o_frame_err
);
    localparam int unsigned NPIX = HDISP * VDISP;
    localparam int unsigned CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int unsigned XW   = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int unsigned YW   = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] CNT_MAX = CW'(NPIX - 1);
    localparam logic [XW-1:0] X_MAX   = XW'(HDISP - 1);
    localparam logic [YW-1:0] Y_MAX   = YW'(VDISP - 1);

    typedef enum logic {StWaitSof, StRun} in_state_e;
    typedef enum logic [1:0] {StIdle, StSetup, StBusy} out_state_e;

    // ---------------- input side ----------------
    in_state_e     r_in_st, w_in_st;
    logic [CW-1:0] r_in_cnt, w_in_cnt;
    logic          r_err, w_err;
    logic          w_ready, w_accept, w_push, w_pop, w_full, w_empty;

    always_comb begin
        w_in_st  = r_in_st;
        w_in_cnt = r_in_cnt;
        w_err    = 1'b0;
        w_push   = 1'b0;
        w_ready  = 1'b0;
        // Discarded non-sof pixels need no FIFO space, only a pushed sof does.
        if (r_in_st == StWaitSof) begin
            w_ready = !w_full || !io_bus.pix_sof;
        end else begin
            w_ready = !w_full;
        end
        if (i_rst) begin
            w_ready = 1'b0;
        end
        w_accept = io_bus.pix_valid && w_ready;
        unique case (r_in_st)
            StWaitSof: begin
                if (w_accept && io_bus.pix_sof) begin
                    w_push   = 1'b1;
                    w_in_cnt = CW'(1);
                    w_in_st  = StRun;
                end
            end
            StRun: begin
                if (w_accept) begin
                    w_push = 1'b1;
                    if (io_bus.pix_sof) begin
                        w_in_cnt = CW'(1);
                        w_err    = 1'b1;
                    end else if (r_in_cnt == CNT_MAX) begin
                        w_in_cnt = '0;
                        w_in_st  = StWaitSof;
                    end else begin
                        w_in_cnt = r_in_cnt + CW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_in_st  <= StWaitSof;
            r_in_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            r_in_st  <= w_in_st;
            r_in_cnt <= w_in_cnt;
            r_err    <= w_err;
        end
    end

    // ---------------- pixel FIFO {sof, data} ----------------
    logic [16:0] r_mem [FIFO_DEPTH];
    logic [AW:0] r_wptr, r_rptr;
    logic [16:0] w_head;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_head  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= {io_bus.pix_sof, io_bus.pix_data};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (AW + 1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (AW + 1)'(1);
        end
    end

    // ---------------- Wishbone master ----------------
    // r_out_x/y: position of the pixel on the bus (Setup/Busy) or of the next one (Idle).
    out_state_e    r_out_st, w_out_st;
    logic [XW-1:0] r_out_x, w_out_x, w_adv_x, w_base_x, w_ld_x;
    logic [YW-1:0] r_out_y, w_out_y, w_adv_y, w_base_y, w_ld_y;
    logic [31:0]   r_adr, w_adr, w_ld_adr, w_pix_idx;
    logic [15:0]   r_dat, w_dat;
    logic          r_cyc, w_cyc, r_done, w_done, w_ack;

    always_comb begin
        w_adv_x = (r_out_x == X_MAX) ? '0 : r_out_x + XW'(1);
        w_adv_y = r_out_y;
        if (r_out_x == X_MAX) begin
            w_adv_y = (r_out_y == Y_MAX) ? '0 : r_out_y + YW'(1);
        end
        w_ack    = (r_out_st == StBusy) && io_bus.wb_ack;
        w_pop    = !w_empty && ((r_out_st == StIdle) || w_ack);
        w_base_x = w_ack ? w_adv_x : r_out_x;
        w_base_y = w_ack ? w_adv_y : r_out_y;
        w_ld_x   = w_head[16] ? '0 : w_base_x;
        w_ld_y   = w_head[16] ? '0 : w_base_y;
        w_pix_idx = 32'(w_ld_y) * HDISP + 32'(w_ld_x);
        w_ld_adr  = BASE_ADR + {w_pix_idx[30:0], 1'b0};

        w_out_st = r_out_st;
        w_out_x  = r_out_x;
        w_out_y  = r_out_y;
        w_adr    = r_adr;
        w_dat    = r_dat;
        w_cyc    = r_cyc;
        w_done   = 1'b0;
        unique case (r_out_st)
            StIdle: begin
                if (w_pop) begin
                    w_adr    = w_ld_adr;
                    w_dat    = w_head[15:0];
                    w_out_x  = w_ld_x;
                    w_out_y  = w_ld_y;
                    w_out_st = StSetup;
                end
            end
            StSetup: begin
                w_cyc    = 1'b1;
                w_out_st = StBusy;
            end
            StBusy: begin
                if (w_ack) begin
                    w_done = (r_out_x == X_MAX) && (r_out_y == Y_MAX);
                    if (w_pop) begin
                        w_adr   = w_ld_adr;
                        w_dat   = w_head[15:0];
                        w_out_x = w_ld_x;
                        w_out_y = w_ld_y;
                    end else begin
                        w_out_x  = w_adv_x;
                        w_out_y  = w_adv_y;
                        w_cyc    = 1'b0;
                        w_out_st = StIdle;
                    end
                end
            end
            default: w_out_st = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_st <= StIdle;
            r_out_x  <= '0;
            r_out_y  <= '0;
            r_adr    <= BASE_ADR;
            r_dat    <= '0;
            r_cyc    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_out_st <= w_out_st;
            r_out_x  <= w_out_x;
            r_out_y  <= w_out_y;
            r_adr    <= w_adr;
            r_dat    <= w_dat;
            r_cyc    <= w_cyc;
            r_done   <= w_done;
        end
    end

    assign io_bus.pix_ready = w_ready;
    assign io_bus.wb_adr    = r_adr;
    assign io_bus.wb_dat_ms = r_dat;
    assign io_bus.wb_sel    = 2'b11;
    assign io_bus.wb_we     = 1'b1;
    assign io_bus.wb_cti    = 3'b000;
    assign io_bus.wb_bte    = 2'b00;
    assign io_bus.wb_cyc    = r_cyc;
    assign io_bus.wb_stb    = r_cyc;
    assign o_frame_done     = r_done;
    assign o_frame_err      = r_err;
endmodule

// File: tb/tb_fb_writer.sv
// Directed bench for fb_writer: 640x480 instance (a) and 4x2 instance (b) with Wishbone slave models.
module tb_fb_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    initial forever #5 clk = ~clk;

    fb_writer_if ifa ();
    fb_writer_if ifb ();
    logic done_a, err_a, done_b, err_b;

    fb_writer #(.HDISP(640), .VDISP(480), .FIFO_DEPTH(8), .BASE_ADR(32'h0)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .io_bus(ifa), .o_frame_done(done_a), .o_frame_err(err_a)
    );
    fb_writer #(.HDISP(4), .VDISP(2), .FIFO_DEPTH(8), .BASE_ADR(32'h0)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .io_bus(ifb), .o_frame_done(done_b), .o_frame_err(err_b)
    );

    int total = 0;
    int bad = 0;
    // slave ack mode: 0 never, 1 one cycle after stb (alternating), 2 every cycle while stb
    int mode_a = 0;
    int mode_b = 0;
    int nd_a = 0, ne_a = 0, nd_b = 0, ne_b = 0;
    logic [31:0] la_adr [$];
    logic [15:0] la_dat [$];
    logic [31:0] lb_adr [$];
    logic [15:0] lb_dat [$];

    initial begin
        ifa.wb_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ifa.wb_cyc && ifa.wb_stb && (mode_a == 2 || (mode_a == 1 && !ifa.wb_ack))) begin
                ifa.wb_ack = 1'b1;
                la_adr.push_back(ifa.wb_adr);
                la_dat.push_back(ifa.wb_dat_ms);
            end else begin
                ifa.wb_ack = 1'b0;
            end
        end
    end

    initial begin
        ifb.wb_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ifb.wb_cyc && ifb.wb_stb && (mode_b == 2 || (mode_b == 1 && !ifb.wb_ack))) begin
                ifb.wb_ack = 1'b1;
                lb_adr.push_back(ifb.wb_adr);
                lb_dat.push_back(ifb.wb_dat_ms);
            end else begin
                ifb.wb_ack = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (done_a) nd_a++;
        if (err_a)  ne_a++;
        if (done_b) nd_b++;
        if (err_b)  ne_b++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic send(input bit to_b, input logic [15:0] d, input logic s, input string tag);
        bit ok = 1'b0;
        logic acc;
        if (to_b) begin
            ifb.pix_data = d; ifb.pix_sof = s; ifb.pix_valid = 1'b1;
        end else begin
            ifa.pix_data = d; ifa.pix_sof = s; ifa.pix_valid = 1'b1;
        end
        for (int i = 0; i < 100; i++) begin
            #1;
            acc = to_b ? ifb.pix_ready : ifa.pix_ready;
            @(posedge clk);
            @(negedge clk);
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        ifa.pix_valid = 1'b0; ifa.pix_sof = 1'b0;
        ifb.pix_valid = 1'b0; ifb.pix_sof = 1'b0;
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        la_adr.delete(); la_dat.delete();
    endtask

    initial begin
        int k;
        bit seen;
        int stable_bad;
        logic acc;
        logic [31:0] hold_adr;
        logic [15:0] hold_dat;

        ifa.pix_valid = 1'b0; ifa.pix_sof = 1'b0; ifa.pix_data = '0;
        ifb.pix_valid = 1'b0; ifb.pix_sof = 1'b0; ifb.pix_data = '0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ifa.pix_ready), 32'd0);
        chk("rst_cyc", 32'(ifa.wb_cyc), 32'd0);
        chk("rst_stb", 32'(ifa.wb_stb), 32'd0);
        chk("rst_adr", ifa.wb_adr, 32'd0);
        chk("rst_dat", 32'(ifa.wb_dat_ms), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        chk("const_sel", 32'(ifa.wb_sel), 32'd3);
        chk("const_we", 32'(ifa.wb_we), 32'd1);
        chk("const_cti", 32'(ifa.wb_cti), 32'd0);
        chk("const_bte", 32'(ifb.wb_bte), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_ready", 32'(ifa.pix_ready), 32'd1);
        @(negedge clk);

        // 1: three pixels, ack one cycle after stb, latency two edges
        mode_a = 1;
        send(1'b0, 16'hA0A0, 1'b1, "t1_acc0");
        chk("t1_lat_t0", 32'(ifa.wb_stb), 32'd0);
        @(negedge clk);
        chk("t1_lat_t1", 32'(ifa.wb_stb), 32'd0);
        @(negedge clk);
        chk("t1_lat_t2", 32'(ifa.wb_stb), 32'd1);
        chk("t1_lat_adr", ifa.wb_adr, 32'd0);
        chk("t1_lat_dat", 32'(ifa.wb_dat_ms), 32'hA0A0);
        send(1'b0, 16'hA1A1, 1'b0, "t1_acc1");
        send(1'b0, 16'hA2A2, 1'b0, "t1_acc2");
        repeat (30) @(negedge clk);
        chk("t1_nwr", la_adr.size(), 32'd3);
        chk("t1_adr0", la_adr[0], 32'd0);
        chk("t1_adr1", la_adr[1], 32'd2);
        chk("t1_adr2", la_adr[2], 32'd4);
        chk("t1_dat0", 32'(la_dat[0]), 32'hA0A0);
        chk("t1_dat1", 32'(la_dat[1]), 32'hA1A1);
        chk("t1_dat2", 32'(la_dat[2]), 32'hA2A2);

        // 5: sof three pixels into a frame -> one frame_err, restart at (0,0)
        chk("t5_err_before", 32'(ne_a), 32'd0);
        send(1'b0, 16'h5A5A, 1'b1, "t5_acc_sof");
        send(1'b0, 16'h1234, 1'b0, "t5_acc_next");
        repeat (30) @(negedge clk);
        chk("t5_err_cnt", 32'(ne_a), 32'd1);
        chk("t5_nwr", la_adr.size(), 32'd5);
        chk("t5_sof_adr", la_adr[3], 32'd0);
        chk("t5_sof_dat", 32'(la_dat[3]), 32'h5A5A);
        chk("t5_next_adr", la_adr[4], 32'd2);
        chk("t5_next_dat", 32'(la_dat[4]), 32'h1234);

        // 2: 4x2 frame, ack always -> 8 writes, one frame_done, back to waiting for sof
        mode_b = 2;
        k = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            ifb.pix_valid = 1'b1;
            ifb.pix_data  = 16'(32'h0100 + k);
            ifb.pix_sof   = (k == 0);
            #1 acc = ifb.pix_ready;
            @(posedge clk);
            @(negedge clk);
            if (acc) k++;
        end
        ifb.pix_valid = 1'b0; ifb.pix_sof = 1'b0;
        chk("t2_acc", 32'(k), 32'd8);
        repeat (20) @(negedge clk);
        chk("t2_nwr", lb_adr.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("t2_adr", lb_adr[i], 32'(2 * i));
            chk("t2_dat", 32'(lb_dat[i]), 32'(32'h0100 + i));
        end
        chk("t2_done_cnt", 32'(nd_b), 32'd1);
        chk("t2_err_cnt", 32'(ne_b), 32'd0);
        send(1'b1, 16'h7777, 1'b0, "t2_acc_drop");
        repeat (10) @(negedge clk);
        chk("t2_drop_nwr", lb_adr.size(), 32'd8);
        send(1'b1, 16'h8888, 1'b0 | 1'b1, "t2_acc_sof");
        repeat (10) @(negedge clk);
        chk("t2_new_nwr", lb_adr.size(), 32'd9);
        chk("t2_new_adr", lb_adr[8], 32'd0);
        chk("t2_new_dat", 32'(lb_dat[8]), 32'h8888);
        chk("a_done_none", 32'(nd_a), 32'd0);

        // 3: non-sof pixels after reset are dropped
        do_reset();
        mode_a = 2;
        for (int i = 0; i < 5; i++) send(1'b0, 16'(32'h0E00 + i), 1'b0, "t3_acc_drop");
        repeat (10) @(negedge clk);
        chk("t3_drop_nwr", la_adr.size(), 32'd0);
        send(1'b0, 16'hBEEF, 1'b1, "t3_acc_sof");
        repeat (10) @(negedge clk);
        chk("t3_nwr", la_adr.size(), 32'd1);
        chk("t3_adr", la_adr[0], 32'd0);
        chk("t3_dat", 32'(la_dat[0]), 32'hBEEF);

        // 4: stalled bus; FIFO_DEPTH pixels queue behind the one on the bus
        do_reset();
        mode_a = 0;
        k = 0; seen = 1'b0; stable_bad = 0; hold_adr = '0; hold_dat = '0;
        for (int c = 0; c < 20; c++) begin
            ifa.pix_valid = 1'b1;
            ifa.pix_data  = 16'(32'hC000 + k);
            ifa.pix_sof   = (k == 0);
            #1 acc = ifa.pix_ready;
            @(posedge clk);
            @(negedge clk);
            if (acc) k++;
            if (ifa.wb_cyc) begin
                if (!seen) begin
                    seen = 1'b1; hold_adr = ifa.wb_adr; hold_dat = ifa.wb_dat_ms;
                end else if (ifa.wb_adr !== hold_adr || ifa.wb_dat_ms !== hold_dat) begin
                    stable_bad++;
                end
            end
        end
        ifa.pix_data = 16'(32'hC000 + k);
        ifa.pix_sof  = 1'b0;
        #1;
        chk("t4_fill_cnt", 32'(k), 32'd9);
        chk("t4_full_ready", 32'(ifa.pix_ready), 32'd0);
        chk("t4_seen_cyc", 32'(seen), 32'd1);
        chk("t4_hold_adr", hold_adr, 32'd0);
        chk("t4_hold_dat", 32'(hold_dat), 32'hC000);
        chk("t4_stable", 32'(stable_bad), 32'd0);
        @(negedge clk);
        mode_a = 1;
        for (int c = 0; c < 100 && k < 12; c++) begin
            ifa.pix_valid = 1'b1;
            ifa.pix_data  = 16'(32'hC000 + k);
            #1 acc = ifa.pix_ready;
            @(posedge clk);
            @(negedge clk);
            if (acc) k++;
        end
        ifa.pix_valid = 1'b0;
        repeat (60) @(negedge clk);
        chk("t4_nwr", la_adr.size(), 32'd12);
        for (int i = 0; i < 12; i++) begin
            chk("t4_adr", la_adr[i], 32'(2 * i));
            chk("t4_dat", 32'(la_dat[i]), 32'(32'hC000 + i));
        end

        // 6: reset mid-cycle with four entries queued
        do_reset();
        mode_a = 0;
        send(1'b0, 16'h3000, 1'b1, "t6_acc0");
        for (int i = 1; i < 5; i++) send(1'b0, 16'(32'h3000 + i), 1'b0, "t6_acc");
        chk("t6_cyc_before", 32'(ifa.wb_cyc), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_cyc_rst", 32'(ifa.wb_cyc), 32'd0);
        chk("t6_stb_rst", 32'(ifa.wb_stb), 32'd0);
        rst = 1'b0;
        mode_a = 2;
        repeat (20) @(negedge clk);
        chk("t6_flushed", la_adr.size(), 32'd0);
        send(1'b0, 16'h1111, 1'b0, "t6_acc_drop");
        repeat (10) @(negedge clk);
        chk("t6_drop_nwr", la_adr.size(), 32'd0);
        send(1'b0, 16'h2222, 1'b1, "t6_acc_sof");
        repeat (10) @(negedge clk);
        chk("t6_nwr", la_adr.size(), 32'd1);
        chk("t6_adr", la_adr[0], 32'd0);
        chk("t6_dat", 32'(la_dat[0]), 32'h2222);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
